// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arb_if.sv
// rtl/dmem_arb_if.sv - requester ports and data_mem bus bundled for the arbiter
interface dmem_arb_if #(
    parameter int AW = 14
);
    logic          p0_req;
    logic          p0_we;
    logic          p0_lock;
    logic [31:0]   p0_addr;
    logic [31:0]   p0_wdata;
    logic          p0_gnt;
    logic [31:0]   p0_rdata;

    logic          p1_req;
    logic          p1_we;
    logic          p1_lock;
    logic [31:0]   p1_addr;
    logic [31:0]   p1_wdata;
    logic          p1_gnt;
    logic [31:0]   p1_rdata;
    logic          p1_starved;

    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [31:0]   mem_d;
    logic [31:0]   mem_spo;

    // Requesters and the memory model: drive requests and read data, observe grants.
    modport master (
        output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        input  p0_gnt, p0_rdata,
        output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        input  p1_gnt, p1_rdata, p1_starved,
        input  mem_a, mem_we, mem_d,
        output mem_spo
    );

    // Arbiter view.
    modport slave (
        input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        output p0_gnt, p0_rdata,
        input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        output p1_gnt, p1_rdata, p1_starved,
        output mem_a, mem_we, mem_d,
        input  mem_spo
    );
endinterface

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - saturating count of consecutive cycles port 1 was denied
module arb_wait_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    input  logic       gnt_i,
    output logic [3:0] cnt_o,
    output logic       sat_o
);
    localparam logic [3:0] MAX_C = 4'(MAX_WAIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Clear on a grant, count denied requests up to the ceiling, hold otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (gnt_i) begin
            cnt_d = 4'd0;
        end else if (req_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == MAX_C);
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority two-port arbiter for data_mem with lock and anti-starvation
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 14,
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_arb_if.slave  bus
);
    arb_state_e state_q;
    arb_state_e state_d;
    logic       g0;
    logic       g1;
    logic       sel;
    logic       starved;
    logic [3:0] wait_cnt;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (bus.p1_req),
        .gnt_i (g1),
        .cnt_o (wait_cnt),
        .sat_o (starved)
    );

    // Grant decision: lock owner is exclusive; in IDLE a starved port 1 beats the CPU.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.p1_req && starved) begin
                    g1 = 1'b1;
                end else if (bus.p0_req) begin
                    g0 = 1'b1;
                end else if (bus.p1_req) begin
                    g1 = 1'b1;
                end
            end
            ST_OWN0: g0 = bus.p0_req;
            ST_OWN1: g1 = bus.p1_req;
            default: begin
                g0 = 1'b0;
                g1 = 1'b0;
            end
        endcase
    end

    // Next ownership follows the lock bit of whichever access is granted.
    always_comb begin
        state_d = state_q;
        if (g0) begin
            state_d = bus.p0_lock ? ST_OWN0 : ST_IDLE;
        end else if (g1) begin
            state_d = bus.p1_lock ? ST_OWN1 : ST_IDLE;
        end
    end

    // Ownership register; reset drops any held lock immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus follows port 0 unless port 1 is granted; everything is forced quiet in reset.
    assign sel          = g1 ? PORT1 : PORT0;
    assign bus.p0_gnt   = g0 & rst_n;
    assign bus.p1_gnt   = g1 & rst_n;
    assign bus.mem_a    = !rst_n ? '0
                        : (sel == PORT1) ? bus.p1_addr[AW+1:2] : bus.p0_addr[AW+1:2];
    assign bus.mem_d    = !rst_n ? 32'd0
                        : (sel == PORT1) ? bus.p1_wdata : bus.p0_wdata;
    assign bus.mem_we   = rst_n & ((g0 & bus.p0_we) | (g1 & bus.p1_we));
    assign bus.p0_rdata = bus.mem_spo;
    assign bus.p1_rdata = bus.mem_spo;
    assign bus.p1_starved = starved & rst_n;

    logic unused_bits;
    assign unused_bits = ^{bus.p0_addr[31:AW+2], bus.p0_addr[1:0],
                           bus.p1_addr[31:AW+2], bus.p1_addr[1:0], wait_cnt};
endmodule
